// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one iterative divider core among N requesters.
// Divide-by-zero is answered locally; a stalled core is aborted after TIMEOUT cycles.
module div_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] DVD_IN,
  input  logic [N*W-1:0] DSR_IN,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   RSP_VLD,
  output logic [W-1:0]   Q_OUT,
  output logic [W-1:0]   R_OUT,
  output logic           DZ,
  output logic           ERR,
  output logic           DIV_START,
  output logic [W-1:0]   DIV_DVD,
  output logic [W-1:0]   DIV_DSR,
  input  logic           DIV_DONE,
  input  logic [W-1:0]   DIV_Q,
  input  logic [W-1:0]   DIV_R
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   NL    = (IW + 1)'(N);
  localparam logic [IW-1:0] NM1   = IW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] owner, ptr, win;
  logic          win_vld;
  logic [W-1:0]  win_dvd, win_dsr;
  logic [W-1:0]  dvd_r, dsr_r, q_r, r_r;
  logic          dz_r, err_r;
  logic [TW-1:0] timer;
  logic          timeout;

  // Rotating priority search starting at ptr; the sum never exceeds 2N-2.
  always_comb begin
    logic [IW:0] j;
    win     = '0;
    win_vld = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (IW + 1)'(k);
      if (j >= NL) j = j - NL;
      if (!win_vld && REQ[j[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = j[IW-1:0];
      end
    end
  end

  assign win_dvd = DVD_IN[win*W +: W];
  assign win_dsr = DSR_IN[win*W +: W];
  assign timeout = (timer == TLAST);

  always_comb begin
    state_nx  = state;
    GNT       = '0;
    RSP_VLD   = '0;
    DIV_START = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          GNT[win] = 1'b1;
          state_nx = (win_dsr == '0) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        DIV_START = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (DIV_DONE || timeout) state_nx = S_RESP;
      end
      S_RESP: begin
        RSP_VLD[owner] = 1'b1;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      owner <= '0;
      ptr   <= '0;
      timer <= '0;
      dvd_r <= '0;
      dsr_r <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            owner <= win;
            dvd_r <= win_dvd;
            dsr_r <= win_dsr;
            if (win_dsr == '0) begin
              q_r  <= '1;
              r_r  <= win_dvd;
              dz_r <= 1'b1;
            end
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          // A completion on the final timer cycle still counts as success.
          if (DIV_DONE) begin
            q_r <= DIV_Q;
            r_r <= DIV_R;
          end else if (timeout) begin
            q_r   <= '0;
            r_r   <= '0;
            err_r <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= (owner == NM1) ? '0 : owner + 1'b1;
          dz_r  <= 1'b0;
          err_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Q_OUT   = (state == S_RESP) ? q_r : '0;
  assign R_OUT   = (state == S_RESP) ? r_r : '0;
  assign DZ      = dz_r;
  assign ERR     = err_r;
  assign DIV_DVD = dvd_r;
  assign DIV_DSR = dsr_r;

endmodule
